// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : song_sequencer
// Purpose  : Walks a melody stored in an external song ROM. For each note
//            word it presents the half-period count to the tone divider,
//            gates the tone enable for the note duration minus a short
//            articulation gap, then fetches the next word. An end marker
//            either finishes the song (done pulse) or restarts it (loop).
// Ports    : clk           - system clock
//            rst           - asynchronous active-high reset
//            start_i       - begin playback from address 0 when idle
//            stop_i        - abort playback (wins over start)
//            loop_i        - sampled at the end marker, 1 = restart song
//            rom_addr_o    - song ROM address
//            rom_data_i    - {half_period[HP_W-1:0], duration[3:0]}
//            half_period_o - divider terminal count for the current note
//            tone_en_o     - tone divider enable
//            busy_o        - high whenever not idle
//            done_o        - one-cycle pulse on natural end of song
// Revision : 1.0 - initial release
// ============================================================================
module song_sequencer #(
   parameter int ADDR_W      = 6,
   parameter int HP_W        = 17,
   parameter int UNIT_CYCLES = 12_500_000,
   parameter int GAP_CYCLES  = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              loop_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [HP_W+3:0]   rom_data_i,
   output logic [HP_W-1:0]   half_period_o,
   output logic              tone_en_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

   // Last prescaler count of a unit, and the count at which the final unit
   // of a note hands over to the silent gap.
   localparam logic [PW-1:0] c_presc_last = PW'(UNIT_CYCLES - 1);
   localparam logic [PW-1:0] c_gap_start  = PW'(UNIT_CYCLES - GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_PLAY  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [HP_W-1:0]   hp_q,    hp_d;
   logic              tone_q,  tone_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [3:0]        units_q, units_d;

   logic [3:0]        w_dur;
   logic [HP_W-1:0]   w_hp;

   assign w_dur = rom_data_i[3:0];
   assign w_hp  = rom_data_i[HP_W+3:4];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         hp_q    <= '0;
         tone_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         presc_q <= '0;
         units_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         hp_q    <= hp_d;
         tone_q  <= tone_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         presc_q <= presc_d;
         units_q <= units_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      hp_d    = hp_q;
      tone_d  = tone_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      presc_d = presc_q;
      units_d = units_q;

      case (state_q)
         S_IDLE: begin
            if (start_i && !stop_i) begin
               state_d = S_FETCH;
               addr_d  = '0;
               busy_d  = 1'b1;
            end
         end

         S_FETCH: begin
            if (w_dur == 4'd0) begin
               // An end marker at address 0 is an empty song: never loop it,
               // otherwise we would spin in FETCH forever.
               if (loop_i && (addr_q != '0)) begin
                  addr_d = '0;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else begin
               hp_d    = w_hp;
               units_d = w_dur;
               presc_d = '0;
               tone_d  = (w_hp != '0);
               state_d = S_PLAY;
            end
         end

         S_PLAY: begin
            if (presc_q == c_presc_last) begin
               presc_d = '0;
               units_d = units_q - 4'd1;
            end else begin
               presc_d = presc_q + PW'(1);
            end
            if ((units_q == 4'd1) && (presc_q == c_gap_start)) begin
               state_d = S_GAP;
               tone_d  = 1'b0;
            end
         end

         S_GAP: begin
            tone_d  = 1'b0;
            presc_d = presc_q + PW'(1);
            if (presc_q == c_presc_last) begin
               presc_d = '0;
               addr_d  = addr_q + ADDR_W'(1);
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides everything once playback has begun.
      if (stop_i && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         addr_d  = '0;
         hp_d    = '0;
         tone_d  = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         presc_d = '0;
         units_d = '0;
      end
   end

   assign rom_addr_o    = addr_q;
   assign half_period_o = hp_q;
   assign tone_en_o     = tone_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_song_sequencer
// Purpose  : Directed self-checking bench for song_sequencer with short
//            timing (10 clocks per unit, 2-clock gap, 16-entry ROM).
// Revision : 1.0 - initial release
// ============================================================================
module tb_song_sequencer;

   localparam int ADDR_W      = 4;
   localparam int HP_W        = 17;
   localparam int UNIT_CYCLES = 10;
   localparam int GAP_CYCLES  = 2;
   localparam int NTR         = 128;

   logic              clk = 1'b0;
   logic              rst;
   logic              start_i;
   logic              stop_i;
   logic              loop_i;
   logic [ADDR_W-1:0] rom_addr_o;
   logic [HP_W+3:0]   rom_data_i;
   logic [HP_W-1:0]   half_period_o;
   logic              tone_en_o;
   logic              busy_o;
   logic              done_o;

   logic [HP_W+3:0]   rom [16];
   assign rom_data_i = rom[rom_addr_o];

   // Per-cycle trace of the outputs, index 0 = first cycle after start edge.
   logic [NTR-1:0]    tr_tone;
   logic [NTR-1:0]    tr_busy;
   logic [NTR-1:0]    tr_done;
   logic [HP_W-1:0]   tr_hp   [NTR];
   logic [ADDR_W-1:0] tr_addr [NTR];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   song_sequencer #(
      .ADDR_W      (ADDR_W),
      .HP_W        (HP_W),
      .UNIT_CYCLES (UNIT_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .stop_i        (stop_i),
      .loop_i        (loop_i),
      .rom_addr_o    (rom_addr_o),
      .rom_data_i    (rom_data_i),
      .half_period_o (half_period_o),
      .tone_en_o     (tone_en_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   task automatic check_value(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int count_bits(input logic [NTR-1:0] v, input int lo,
                                     input int hi);
      int c = 0;
      for (int i = lo; i <= hi; i++) if (v[i]) c++;
      return c;
   endfunction

   function automatic int first_one(input logic [NTR-1:0] v);
      for (int i = 0; i < NTR; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int last_one(input logic [NTR-1:0] v);
      for (int i = NTR - 1; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = '0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulse start for one edge, then record n cycles. At trace index i the
   // bench may drop loop, hold start high, or pulse stop for the next edge.
   task automatic capture(input int n, input int loop_off_at, input int s0,
                          input int s1, input int stop_at);
      tr_tone = '0;
      tr_busy = '0;
      tr_done = '0;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      for (int i = 0; i < n; i++) begin
         tr_tone[i] = tone_en_o;
         tr_busy[i] = busy_o;
         tr_done[i] = done_o;
         tr_hp[i]   = half_period_o;
         tr_addr[i] = rom_addr_o;
         if (i == loop_off_at) loop_i = 1'b0;
         start_i = (i >= s0) && (i <= s1);
         stop_i  = (i == stop_at);
         @(posedge clk);
         #1;
      end
      start_i = 1'b0;
      stop_i  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      start_i = 1'b0;
      stop_i  = 1'b0;
      loop_i  = 1'b0;
      clear_rom();
      #12;
      check_value("rst_addr",  32'(rom_addr_o),    32'd0);
      check_value("rst_hp",    32'(half_period_o), 32'd0);
      check_value("rst_tone",  32'(tone_en_o),     32'd0);
      check_value("rst_busy",  32'(busy_o),        32'd0);
      check_value("rst_done",  32'(done_o),        32'd0);
      rst = 1'b0;
      idle_cycles(2);

      // ---------------- single note ----------------
      clear_rom();
      rom[0] = {17'd101240, 4'd2};
      capture(32, -1, -1, -2, -1);
      check_value("one_busy_rise",  32'(tr_busy[0]), 32'd1);
      check_value("one_tone_first", 32'(first_one(tr_tone)), 32'd1);
      check_value("one_tone_last",  32'(last_one(tr_tone)), 32'd18);
      check_value("one_tone_cnt",   32'(count_bits(tr_tone, 0, 31)), 32'd18);
      check_value("one_hp",         32'(tr_hp[1]), 32'd101240);
      check_value("one_fetch_addr", 32'(tr_addr[21]), 32'd1);
      check_value("one_busy_fetch", 32'(tr_busy[21]), 32'd1);
      check_value("one_done_pos",   32'(tr_done[22]), 32'd1);
      check_value("one_busy_fall",  32'(tr_busy[22]), 32'd0);
      check_value("one_done_cnt",   32'(count_bits(tr_done, 0, 31)), 32'd1);
      idle_cycles(2);

      // ---------------- rest then note ----------------
      clear_rom();
      rom[0] = {17'd0, 4'd1};
      rom[1] = {17'd50000, 4'd1};
      capture(30, -1, -1, -2, -1);
      check_value("rest_silent",  32'(count_bits(tr_tone, 0, 11)), 32'd0);
      check_value("rest_first",   32'(first_one(tr_tone)), 32'd12);
      check_value("rest_cnt",     32'(count_bits(tr_tone, 0, 29)), 32'd8);
      check_value("rest_hp",      32'(tr_hp[12]), 32'd50000);
      check_value("rest_done",    32'(tr_done[23]), 32'd1);
      idle_cycles(2);

      // ---------------- loop, then release loop ----------------
      clear_rom();
      rom[0] = {17'd101240, 4'd2};
      loop_i = 1'b1;
      capture(48, 30, -1, -2, -1);
      check_value("loop_addr_end",  32'(tr_addr[21]), 32'd1);
      check_value("loop_addr_wrap", 32'(tr_addr[22]), 32'd0);
      check_value("loop_fetch2",    32'(tr_tone[22]), 32'd0);
      check_value("loop_note2_on",  32'(tr_tone[23]), 32'd1);
      check_value("loop_note2_end", 32'(tr_tone[41]), 32'd0);
      check_value("loop_tone_cnt",  32'(count_bits(tr_tone, 0, 43)), 32'd36);
      check_value("loop_hp2",       32'(tr_hp[23]), 32'd101240);
      check_value("loop_no_done",   32'(count_bits(tr_done, 0, 43)), 32'd0);
      check_value("loop_busy_hold", 32'(tr_busy[43]), 32'd1);
      check_value("loop_off_done",  32'(tr_done[44]), 32'd1);
      idle_cycles(2);

      // ---------------- start while busy, then stop mid-note ----------------
      clear_rom();
      rom[0] = {17'd101240, 4'd2};
      capture(12, -1, 1, 3, 5);
      check_value("stop_no_restart", 32'(count_bits(tr_tone, 1, 5)), 32'd5);
      check_value("stop_tone",  32'(tr_tone[6]), 32'd0);
      check_value("stop_busy",  32'(tr_busy[6]), 32'd0);
      check_value("stop_addr",  32'(tr_addr[6]), 32'd0);
      check_value("stop_hp",    32'(tr_hp[6]), 32'd0);
      check_value("stop_done",  32'(count_bits(tr_done, 0, 11)), 32'd0);
      check_value("stop_idle",  32'(count_bits(tr_busy, 6, 11)), 32'd0);
      idle_cycles(2);

      // ---------------- empty song with loop set ----------------
      clear_rom();
      loop_i = 1'b1;
      capture(6, -1, -1, -2, -1);
      check_value("empty_busy",  32'(count_bits(tr_busy, 0, 5)), 32'd1);
      check_value("empty_done",  32'(tr_done[1]), 32'd1);
      check_value("empty_dcnt",  32'(count_bits(tr_done, 0, 5)), 32'd1);
      check_value("empty_tone",  32'(count_bits(tr_tone, 0, 5)), 32'd0);
      loop_i = 1'b0;
      idle_cycles(2);

      // ---------------- async reset during second note ----------------
      clear_rom();
      rom[0] = {17'd0, 4'd1};
      rom[1] = {17'd50000, 4'd1};
      capture(15, -1, -1, -2, -1);
      #2;
      check_value("pre_rst_tone", 32'(tone_en_o), 32'd1);
      rst = 1'b1;
      #1;
      check_value("arst_tone", 32'(tone_en_o),     32'd0);
      check_value("arst_busy", 32'(busy_o),        32'd0);
      check_value("arst_addr", 32'(rom_addr_o),    32'd0);
      check_value("arst_hp",   32'(half_period_o), 32'd0);
      check_value("arst_done", 32'(done_o),        32'd0);
      #2;
      rst = 1'b0;
      idle_cycles(2);
      check_value("post_rst_idle", 32'(busy_o), 32'd0);
      capture(26, -1, -1, -2, -1);
      check_value("replay_addr0", 32'(tr_addr[0]), 32'd0);
      check_value("replay_first", 32'(first_one(tr_tone)), 32'd12);
      check_value("replay_hp",    32'(tr_hp[12]), 32'd50000);
      check_value("replay_done",  32'(tr_done[23]), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
